// File: rtl/loader_pkg.sv
// Shared types and constants for the UART program loader.
//   state_t        : loader FSM states
//   LEN_W          : width of the word-count header
//   BYTES_PER_WORD : bytes assembled into one ROM word
package loader_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LEN_LO = 3'd1,
        LEN_HI = 3'd2,
        DATA   = 3'd3,
        CHK    = 3'd4,
        DONE   = 3'd5,
        ERR    = 3'd6
    } state_t;

    localparam int LEN_W          = 16;
    localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/loader_timer.sv
// Inter-byte idle timer for the program loader.
// Down-counter reloaded on clr; counts while en is high. expired is raised
// on the CYC-th consecutive enabled cycle without a clear.
//   clk, rst : clock, synchronous active-high reset
//   clr      : reload the counter (byte received or session restart)
//   en       : count this cycle (loader is in an active state)
//   expired  : terminal count reached this cycle
module loader_timer #(
    parameter int CYC = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CW = (CYC > 1) ? $clog2(CYC) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = CW'(CYC - 1);
        end else if (en && cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    assign expired = en && !clr && (cnt_q == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= CW'(CYC - 1);
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_prog_loader.sv
// UART boot loader: receives LEN_LO, LEN_HI (word count N) then 4*N bytes,
// assembles little-endian words and writes them to the instruction ROM
// programming port at addresses 0..N-1, holding the CPU in reset meanwhile.
// Optional feature macro: LOADER_CHECKSUM_EN adds a trailing XOR checksum byte.
//   clk, rst          : clock, synchronous active-high reset
//   start_i           : arm/restart a load session
//   rx_valid_i/data_i : received byte strobe and value
//   upg_rst_o         : hold CPU in reset (loading or error)
//   upg_wen_o/adr_o/dat_o : ROM write port
//   upg_done_o, err_o : session result levels
//   words_o           : words written in the current/last session
//
// state  | meaning
// IDLE   | after reset, waiting for start_i
// LEN_LO | waiting for low byte of word count
// LEN_HI | waiting for high byte of word count
// DATA   | assembling and writing words
// CHK    | waiting for checksum byte (LOADER_CHECKSUM_EN only)
// DONE   | load succeeded, CPU released
// ERR    | load aborted, CPU held in reset
module uart_prog_loader
    import loader_pkg::*;
#(
    parameter int ADDR_W      = 14,
    parameter int TIMEOUT_CYC = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              rx_valid_i,
    input  logic [7:0]        rx_data_i,
    output logic              upg_rst_o,
    output logic              upg_wen_o,
    output logic [ADDR_W-1:0] upg_adr_o,
    output logic [31:0]       upg_dat_o,
    output logic              upg_done_o,
    output logic              err_o,
    output logic [ADDR_W:0]   words_o
);

    localparam int unsigned CAP = 32'd1 << ADDR_W;
`ifdef LOADER_CHECKSUM_EN
    localparam state_t END_ST = CHK;
`else
    localparam state_t END_ST = DONE;
`endif

    state_t            state_q, state_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [1:0]        byte_idx_q, byte_idx_d;
    logic [23:0]       asm_q, asm_d;
    logic [ADDR_W:0]   word_idx_q, word_idx_d;
    logic              wen_q, wen_d;
    logic [ADDR_W-1:0] adr_q, adr_d;
    logic [31:0]       dat_q, dat_d;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]        csum_q, csum_d;
`endif

    logic             active;
    logic             timeout;
    logic [LEN_W-1:0] len_rx;
    logic             last_written;

    assign active = (state_q == LEN_LO) || (state_q == LEN_HI) ||
                    (state_q == DATA)   || (state_q == CHK);
    assign len_rx = {rx_data_i, len_q[7:0]};
    // word_idx has already advanced when the write strobe is visible
    assign last_written = wen_q && (32'(word_idx_q) == 32'(len_q));

    if (TIMEOUT_CYC > 0) begin : g_timer
        loader_timer #(.CYC(TIMEOUT_CYC)) u_timer (
            .clk     (clk),
            .rst     (rst),
            .clr     (rx_valid_i || start_i),
            .en      (active),
            .expired (timeout)
        );
    end else begin : g_no_timer
        assign timeout = 1'b0;
    end

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        byte_idx_d = byte_idx_q;
        asm_d      = asm_q;
        word_idx_d = word_idx_q;
        wen_d      = 1'b0;
        adr_d      = adr_q;
        dat_d      = dat_q;
`ifdef LOADER_CHECKSUM_EN
        csum_d     = csum_q;
`endif
        // start takes priority over everything, including a same-cycle byte
        if (start_i) begin
            state_d    = LEN_LO;
            len_d      = '0;
            byte_idx_d = '0;
            asm_d      = '0;
            word_idx_d = '0;
`ifdef LOADER_CHECKSUM_EN
            csum_d     = '0;
`endif
        end else if (timeout) begin
            state_d = ERR;
        end else begin
            case (state_q)
                LEN_LO: if (rx_valid_i) begin
                    len_d[7:0] = rx_data_i;
                    state_d    = LEN_HI;
                end
                LEN_HI: if (rx_valid_i) begin
                    len_d = len_rx;
                    if (32'(len_rx) > CAP)    state_d = ERR;
                    else if (len_rx == '0)    state_d = END_ST;
                    else                      state_d = DATA;
                end
                DATA: if (last_written) begin
                    state_d = END_ST;
                end else if (rx_valid_i) begin
`ifdef LOADER_CHECKSUM_EN
                    csum_d = csum_q ^ rx_data_i;
`endif
                    if (byte_idx_q == 2'(BYTES_PER_WORD - 1)) begin
                        wen_d      = 1'b1;
                        adr_d      = word_idx_q[ADDR_W-1:0];
                        dat_d      = {rx_data_i, asm_q};
                        word_idx_d = word_idx_q + (ADDR_W+1)'(1);
                        byte_idx_d = '0;
                    end else begin
                        case (byte_idx_q)
                            2'd0:    asm_d[7:0]   = rx_data_i;
                            2'd1:    asm_d[15:8]  = rx_data_i;
                            default: asm_d[23:16] = rx_data_i;
                        endcase
                        byte_idx_d = byte_idx_q + 2'd1;
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                CHK: if (rx_valid_i) begin
                    state_d = (rx_data_i == csum_q) ? DONE : ERR;
                end
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            len_q      <= '0;
            byte_idx_q <= '0;
            asm_q      <= '0;
            word_idx_q <= '0;
            wen_q      <= 1'b0;
            adr_q      <= '0;
            dat_q      <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            byte_idx_q <= byte_idx_d;
            asm_q      <= asm_d;
            word_idx_q <= word_idx_d;
            wen_q      <= wen_d;
            adr_q      <= adr_d;
            dat_q      <= dat_d;
`ifdef LOADER_CHECKSUM_EN
            csum_q     <= csum_d;
`endif
        end
    end

    assign upg_rst_o  = active || (state_q == ERR);
    assign upg_wen_o  = wen_q;
    assign upg_adr_o  = adr_q;
    assign upg_dat_o  = dat_q;
    assign upg_done_o = (state_q == DONE);
    assign err_o      = (state_q == ERR);
    assign words_o    = word_idx_q;

endmodule

// File: tb/tb_uart_prog_loader.sv
// Self-checking bench for uart_prog_loader (ADDR_W=14, TIMEOUT_CYC=16).
// Table of complete sessions plus hand-written abort/reset/timeout sequences.
module tb_uart_prog_loader;

    localparam int ADDR_W = 14;
    localparam int TCYC   = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              start_i;
    logic              rx_valid_i;
    logic [7:0]        rx_data_i;
    logic              upg_rst_o;
    logic              upg_wen_o;
    logic [ADDR_W-1:0] upg_adr_o;
    logic [31:0]       upg_dat_o;
    logic              upg_done_o;
    logic              err_o;
    logic [ADDR_W:0]   words_o;

    uart_prog_loader #(.ADDR_W(ADDR_W), .TIMEOUT_CYC(TCYC)) dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start_i),
        .rx_valid_i (rx_valid_i),
        .rx_data_i  (rx_data_i),
        .upg_rst_o  (upg_rst_o),
        .upg_wen_o  (upg_wen_o),
        .upg_adr_o  (upg_adr_o),
        .upg_dat_o  (upg_dat_o),
        .upg_done_o (upg_done_o),
        .err_o      (err_o),
        .words_o    (words_o)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // write log filled by the monitor
    int                wen_total = 0;
    logic [ADDR_W-1:0] log_adr [64];
    logic [31:0]       log_dat [64];
    logic              prev_wen = 1'b0;

    always @(negedge clk) begin
        if (prev_wen) chk("wen_one_cycle", 32'(upg_wen_o), 32'd0);
        if (upg_wen_o) begin
            log_adr[wen_total % 64] = upg_adr_o;
            log_dat[wen_total % 64] = upg_dat_o;
            wen_total++;
        end
        prev_wen = upg_wen_o;
    end

    task automatic pulse_start(input bit with_rx, input logic [7:0] b);
        @(negedge clk);
        start_i = 1'b1; rx_valid_i = with_rx; rx_data_i = b;
        @(negedge clk);
        start_i = 1'b0; rx_valid_i = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_valid_i = 1'b1; rx_data_i = b;
        @(negedge clk);
        rx_valid_i = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    typedef struct {
        string        name;
        int           nb;      // bytes to send
        logic [127:0] bytes;   // first byte in the top bits
        int           nw;      // expected writes
        logic [95:0]  dat;     // expected words, word 0 in the top bits
        int           words;
        bit           done;
        bit           err;
    } vec_t;

    function automatic vec_t mkv(input string nm, input int nb, input logic [127:0] b,
                                 input int nw, input logic [95:0] d, input int words,
                                 input bit done, input bit err);
        vec_t v;
        v.name = nm; v.nb = nb; v.bytes = b; v.nw = nw; v.dat = d;
        v.words = words; v.done = done; v.err = err;
        return v;
    endfunction

`ifdef LOADER_CHECKSUM_EN
    localparam int NV = 6;
`else
    localparam int NV = 5;
`endif
    vec_t vecs [NV];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int base;
        int k;
        logic [127:0] bb;
        logic [95:0]  dd;

`ifdef LOADER_CHECKSUM_EN
        vecs[0] = mkv("normal", 11, 128'h0200_7856_3412_EFBE_ADDE_2A00_0000_0000,
                      2, {32'h12345678, 32'hDEADBEEF, 32'h0}, 2, 1, 0);
        vecs[1] = mkv("empty", 3, 128'h0, 0, 96'h0, 0, 1, 0);
        vecs[2] = mkv("oversize", 2, 128'h0140_0000_0000_0000_0000_0000_0000_0000,
                      0, 96'h0, 0, 0, 1);
        vecs[3] = mkv("single", 7, 128'h0100_0102_0304_0400_0000_0000_0000_0000,
                      1, {32'h04030201, 64'h0}, 1, 1, 0);
        vecs[4] = mkv("three", 15, 128'h0300_1122_3344_5566_7788_99AA_BBCC_CC00,
                      3, {32'h44332211, 32'h88776655, 32'hCCBBAA99}, 3, 1, 0);
        vecs[5] = mkv("bad_csum", 7, 128'h0100_0102_0304_0500_0000_0000_0000_0000,
                      1, {32'h04030201, 64'h0}, 1, 0, 1);
`else
        vecs[0] = mkv("normal", 10, 128'h0200_7856_3412_EFBE_ADDE_0000_0000_0000,
                      2, {32'h12345678, 32'hDEADBEEF, 32'h0}, 2, 1, 0);
        vecs[1] = mkv("empty", 2, 128'h0, 0, 96'h0, 0, 1, 0);
        vecs[2] = mkv("oversize", 2, 128'h0140_0000_0000_0000_0000_0000_0000_0000,
                      0, 96'h0, 0, 0, 1);
        vecs[3] = mkv("single", 6, 128'h0100_0102_0304_0000_0000_0000_0000_0000,
                      1, {32'h04030201, 64'h0}, 1, 1, 0);
        vecs[4] = mkv("three", 14, 128'h0300_1122_3344_5566_7788_99AA_BBCC_0000,
                      3, {32'h44332211, 32'h88776655, 32'hCCBBAA99}, 3, 1, 0);
`endif

        rst = 1'b1; start_i = 1'b0; rx_valid_i = 1'b0; rx_data_i = 8'h00;
        idle(3);
        rst = 1'b0;
        idle(1);
        chk("reset_upg_rst", 32'(upg_rst_o), 32'd0);
        chk("reset_wen",     32'(upg_wen_o), 32'd0);
        chk("reset_adr",     32'(upg_adr_o), 32'd0);
        chk("reset_dat",     upg_dat_o,      32'd0);
        chk("reset_done",    32'(upg_done_o), 32'd0);
        chk("reset_err",     32'(err_o),     32'd0);
        chk("reset_words",   32'(words_o),   32'd0);

        // bytes before any start are ignored
        send_byte(8'h01);
        idle(2);
        chk("idle_ignores_rx", 32'(upg_rst_o), 32'd0);

        for (int i = 0; i < NV; i++) begin
            base = wen_total;
            pulse_start(1'b0, 8'h00);
            chk({vecs[i].name, "_rst_after_start"}, 32'(upg_rst_o), 32'd1);
            bb = vecs[i].bytes;
            for (int j = 0; j < vecs[i].nb; j++) send_byte(bb[127-8*j -: 8]);
            idle(4);
            chk({vecs[i].name, "_wen_count"}, 32'(wen_total - base), 32'(vecs[i].nw));
            dd = vecs[i].dat;
            for (int w = 0; w < vecs[i].nw; w++) begin
                chk({vecs[i].name, "_adr"}, 32'(log_adr[(base + w) % 64]), 32'(w));
                chk({vecs[i].name, "_dat"}, log_dat[(base + w) % 64], dd[95-32*w -: 32]);
            end
            chk({vecs[i].name, "_words"}, 32'(words_o), 32'(vecs[i].words));
            chk({vecs[i].name, "_done"}, 32'(upg_done_o), 32'(vecs[i].done));
            chk({vecs[i].name, "_err"}, 32'(err_o), 32'(vecs[i].err));
            chk({vecs[i].name, "_upg_rst"}, 32'(upg_rst_o), 32'(!vecs[i].done));
        end

        // empty load reaches its end state on the cycle after LEN_HI
        pulse_start(1'b0, 8'h00);
        send_byte(8'h00);
        send_byte(8'h00);
`ifdef LOADER_CHECKSUM_EN
        chk("empty_in_chk", 32'(upg_rst_o), 32'd1);
        send_byte(8'h00);
`endif
        chk("empty_done_next_cycle", 32'(upg_done_o), 32'd1);

        // timeout: N=2 but only 5 data bytes
        base = wen_total;
        pulse_start(1'b0, 8'h00);
        send_byte(8'h02); send_byte(8'h00);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
        send_byte(8'h05);
        k = 1;
        while (k <= 40) begin
            @(negedge clk);
            if (err_o) break;
            k++;
        end
        chk("timeout_cycles", 32'(k), 32'd16);
        chk("timeout_wen_count", 32'(wen_total - base), 32'd1);
        chk("timeout_upg_rst", 32'(upg_rst_o), 32'd1);
        chk("timeout_words", 32'(words_o), 32'd1);

        // abort after 3 data bytes; the restarting start carries a byte that must be dropped
        base = wen_total;
        pulse_start(1'b0, 8'h00);
        send_byte(8'h02); send_byte(8'h00);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
        pulse_start(1'b1, 8'hFF);
        idle(2);
        chk("abort_no_wen", 32'(wen_total - base), 32'd0);
        chk("abort_words", 32'(words_o), 32'd0);
        chk("abort_upg_rst", 32'(upg_rst_o), 32'd1);
        send_byte(8'h01); send_byte(8'h00);
        send_byte(8'hA1); send_byte(8'hB2); send_byte(8'hC3); send_byte(8'hD4);
`ifdef LOADER_CHECKSUM_EN
        send_byte(8'h04);
`endif
        idle(4);
        chk("restart_wen_count", 32'(wen_total - base), 32'd1);
        chk("restart_adr", 32'(log_adr[base % 64]), 32'd0);
        chk("restart_dat", log_dat[base % 64], 32'hD4C3B2A1);
        chk("restart_done", 32'(upg_done_o), 32'd1);

        // reset in the middle of the second word
        base = wen_total;
        pulse_start(1'b0, 8'h00);
        send_byte(8'h02); send_byte(8'h00);
        send_byte(8'h78); send_byte(8'h56); send_byte(8'h34); send_byte(8'h12);
        send_byte(8'h9A); send_byte(8'hBC);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_upg_rst", 32'(upg_rst_o), 32'd0);
        chk("midrst_wen", 32'(upg_wen_o), 32'd0);
        chk("midrst_adr", 32'(upg_adr_o), 32'd0);
        chk("midrst_dat", upg_dat_o, 32'd0);
        chk("midrst_words", 32'(words_o), 32'd0);
        chk("midrst_done_err", 32'({upg_done_o, err_o}), 32'd0);
        rst = 1'b0;
        send_byte(8'hDE); send_byte(8'hF0);
        idle(3);
        chk("midrst_wen_count", 32'(wen_total - base), 32'd1);
        chk("midrst_first_word", log_dat[base % 64], 32'h12345678);
        chk("midrst_idle_upg_rst", 32'(upg_rst_o), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
